cpu_loader: RTL and testbench
=============================

CPU_LOADER -- requirements
Module: cpu_loader

Interface
REQ-001 Parameter RST_CYCLES, default 2, number of clock cycles cpu_rst_ is held low after loading.
REQ-002 Parameter MAX_CYCLES, default 16'hFFFF, number of run cycles before a timeout is declared.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to begin a load; sampled only in IDLE or HALTED.
REQ-006 in_valid  input  1  program byte available.
REQ-007 in_data  input  8  program byte: opcode[7:5], address[4:0].
REQ-008 in_last  input  1  qualifies in_data as the final byte of the image.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_write  output  1  one-cycle write strobe to the 32x8 CPU memory.
REQ-011 mem_addr  output  5  memory write address.
REQ-012 mem_data  output  8  memory write data.
REQ-013 cpu_rst_  output  1  active-low reset to the CPU.
REQ-014 halt  input  1  CPU halt indication.
REQ-015 pc_addr  input  5  CPU program counter.
REQ-016 halted  output  1  the run has ended, either by halt or by timeout.
REQ-017 timeout  output  1  the run ended because MAX_CYCLES was reached.
REQ-018 halt_pc  output  5  pc_addr captured at halt.
REQ-019 run_cycles  output  16  count of run cycles.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, FILL, RSTCPU, RUN and HALTED.
REQ-021 IDLE: in_ready=0 and cpu_rst_=0; start=1 moves to LOAD, clears the byte index, halted, timeout, halt_pc and run_cycles.
REQ-022 LOAD: in_ready=1; a byte is accepted when in_valid and in_ready are both high.
REQ-023 For each accepted byte, mem_write=1 on the next cycle, with mem_addr set to the index and mem_data set to the byte; the index then increments.
REQ-024 Cycles without in_valid in LOAD SHALL produce no write and leave the index unchanged.
REQ-025 Accepting index 31 SHALL go to RSTCPU; in_last is then irrelevant, and the index never wraps.
REQ-026 Accepting a byte with in_last=1 and index<31 SHALL go to FILL.
REQ-027 FILL: in_ready=0; write 8'h00 (HLT) to every remaining address, one write per cycle, up to and including 31; then go to RSTCPU.
REQ-028 Every address 0..31 SHALL be written exactly once per load.
REQ-029 RSTCPU: cpu_rst_=0 for exactly RST_CYCLES cycles, then go to RUN.
REQ-030 RUN: cpu_rst_=1; run_cycles increments by one each cycle and saturates.
REQ-031 In RUN, halt=1 SHALL go to HALTED, capture pc_addr into halt_pc, and set halted=1 on the next cycle.
REQ-032 In RUN, run_cycles reaching MAX_CYCLES with halt=0 SHALL go to HALTED with halted=1 and timeout=1; halt_pc keeps its cleared value of 0.
REQ-033 If halt=1 in the same cycle the limit is reached, halt wins and timeout=0.
REQ-034 HALTED: cpu_rst_=1 and all status outputs hold; start=1 restarts exactly as in REQ-021.
REQ-035 start SHALL be ignored in LOAD, FILL, RSTCPU and RUN.
REQ-036 mem_write SHALL be 0 in every state other than LOAD (after an accepted byte) and FILL.

Reset
REQ-037 While rst is high, the block SHALL be in IDLE with in_ready=0, mem_write=0, mem_addr=0, mem_data=0 and cpu_rst_=0.
REQ-038 While rst is high, halted=0, timeout=0, halt_pc=0 and run_cycles=0.
REQ-039 Reset asserted mid-load or mid-run SHALL abort immediately.
REQ-040 Memory contents already written are not cleared by reset.

Verification
REQ-041 Load 32 bytes back-to-back -> 32 writes to addresses 0..31 in order, then cpu_rst_ low for 2 cycles, then high.
REQ-042 Load 3 bytes with in_last on the 3rd -> writes to addresses 0..2, then 29 zero writes to addresses 3..31 with in_ready=0.
REQ-043 Random in_valid gaps during load -> write order and data are identical to the gap-free case.
REQ-044 halt rises while pc_addr=5'h17 -> halted=1, halt_pc=17, timeout=0; run_cycles is frozen.
REQ-045 Run with MAX_CYCLES=20 and halt never set -> halted=1, timeout=1, run_cycles=20.
REQ-046 rst pulsed after 10 bytes are loaded, then start -> the load restarts at address 0 and all status outputs are cleared.

Source files
------------

// File: rtl/cpu_loader.sv
// cpu_loader: streams a program image into a 32x8 CPU memory, pads the
// unused tail with HLT (8'h00), holds the CPU in reset for a fixed number of
// cycles, then supervises the run until the CPU halts or a cycle limit expires.
module cpu_loader #(
  parameter  int unsigned RST_CYCLES = 2,
  parameter  logic [15:0] MAX_CYCLES = 16'hFFFF,
  localparam int unsigned ADDR_W     = 5,
  localparam int unsigned DATA_W     = 8,
  localparam int unsigned CNT_W      = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              cpu_rst_,
  input  logic              halt,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              halted,
  output logic              timeout,
  output logic [ADDR_W-1:0] halt_pc,
  output logic [CNT_W-1:0]  run_cycles
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [DATA_W-1:0] HLT_OP    = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_RSTCPU,
    S_RUN,
    S_HALTED
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  idx;
  logic [ADDR_W-1:0]  idx_nxt;
  logic [CNT_W-1:0]   rst_cnt;
  logic [CNT_W-1:0]   rst_cnt_nxt;
  logic               in_ready_nxt;
  logic               mem_write_nxt;
  logic [ADDR_W-1:0]  mem_addr_nxt;
  logic [DATA_W-1:0]  mem_data_nxt;
  logic               cpu_rst_nxt;
  logic               halted_nxt;
  logic               timeout_nxt;
  logic [ADDR_W-1:0]  halt_pc_nxt;
  logic [CNT_W-1:0]   run_cycles_nxt;
  logic [CNT_W-1:0]   run_inc;

  // Saturating increment of the run-cycle counter
  assign run_inc = (run_cycles == '1) ? run_cycles : run_cycles + CNT_W'(1);

  // Next-state and next-output decode; every output is registered from here
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    rst_cnt_nxt    = rst_cnt;
    mem_write_nxt  = 1'b0;
    mem_addr_nxt   = mem_addr;
    mem_data_nxt   = mem_data;
    halted_nxt     = halted;
    timeout_nxt    = timeout;
    halt_pc_nxt    = halt_pc;
    run_cycles_nxt = run_cycles;

    case (state)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_nxt      = S_LOAD;
          idx_nxt        = '0;
          halted_nxt     = 1'b0;
          timeout_nxt    = 1'b0;
          halt_pc_nxt    = '0;
          run_cycles_nxt = '0;
        end
      end

      S_LOAD: begin
        if (in_valid && in_ready) begin
          mem_write_nxt = 1'b1;
          mem_addr_nxt  = idx;
          mem_data_nxt  = in_data;
          // The top address ends the load whatever in_last says; idx never wraps
          if (idx == LAST_ADDR) begin
            state_nxt   = S_RSTCPU;
            rst_cnt_nxt = '0;
          end else begin
            idx_nxt = idx + ADDR_W'(1);
            if (in_last) begin
              state_nxt = S_FILL;
            end
          end
        end
      end

      S_FILL: begin
        mem_write_nxt = 1'b1;
        mem_addr_nxt  = idx;
        mem_data_nxt  = HLT_OP;
        if (idx == LAST_ADDR) begin
          state_nxt   = S_RSTCPU;
          rst_cnt_nxt = '0;
        end else begin
          idx_nxt = idx + ADDR_W'(1);
        end
      end

      S_RSTCPU: begin
        // The first RSTCPU cycle carries the final memory write, so the CPU
        // sees RST_CYCLES further reset cycles with the memory settled.
        if (rst_cnt >= CNT_W'(RST_CYCLES)) begin
          state_nxt = S_RUN;
        end else begin
          rst_cnt_nxt = rst_cnt + CNT_W'(1);
        end
      end

      S_RUN: begin
        run_cycles_nxt = run_inc;
        if (halt) begin
          state_nxt   = S_HALTED;
          halted_nxt  = 1'b1;
          halt_pc_nxt = pc_addr;
        end else if (run_inc >= MAX_CYCLES) begin
          state_nxt   = S_HALTED;
          halted_nxt  = 1'b1;
          timeout_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    in_ready_nxt = (state_nxt == S_LOAD);
    cpu_rst_nxt  = (state_nxt == S_RUN) || (state_nxt == S_HALTED);
  end

  // State and registered outputs; reset aborts any load or run in progress
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      rst_cnt    <= '0;
      in_ready   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      cpu_rst_   <= 1'b0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
      halt_pc    <= '0;
      run_cycles <= '0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      rst_cnt    <= rst_cnt_nxt;
      in_ready   <= in_ready_nxt;
      mem_write  <= mem_write_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_data   <= mem_data_nxt;
      cpu_rst_   <= cpu_rst_nxt;
      halted     <= halted_nxt;
      timeout    <= timeout_nxt;
      halt_pc    <= halt_pc_nxt;
      run_cycles <= run_cycles_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_loader.sv
// Directed/randomized bench for cpu_loader with a memory-image reference model.
module tb_cpu_loader;

  localparam int unsigned RST_CYC = 2;
  localparam logic [15:0] MAXC    = 16'd20;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        mem_write;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        cpu_rst_;
  logic        halt = 1'b0;
  logic [4:0]  pc_addr = 5'h00;
  logic        halted;
  logic        timeout;
  logic [4:0]  halt_pc;
  logic [15:0] run_cycles;

  int tests = 0;
  int fails = 0;
  logic [7:0] img[$];

  cpu_loader #(.RST_CYCLES(RST_CYC), .MAX_CYCLES(MAXC)) dut (
    .clock      (clock),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .cpu_rst_   (cpu_rst_),
    .halt       (halt),
    .pc_addr    (pc_addr),
    .halted     (halted),
    .timeout    (timeout),
    .halt_pc    (halt_pc),
    .run_cycles (run_cycles)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},   32'(in_ready),   32'd0);
    check({tag, "_mem_write"},  32'(mem_write),  32'd0);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, "_mem_data"},   32'(mem_data),   32'd0);
    check({tag, "_cpu_rst_"},   32'(cpu_rst_),   32'd0);
    check({tag, "_halted"},     32'(halted),     32'd0);
    check({tag, "_timeout"},    32'(timeout),    32'd0);
    check({tag, "_halt_pc"},    32'(halt_pc),    32'd0);
    check({tag, "_run_cycles"}, 32'(run_cycles), 32'd0);
  endtask

  // Start a load of img, feed it with random gaps, and check the resulting memory image
  task automatic do_load(input bit use_last, input int gap_pct);
    int n = img.size();
    int sent = 0;
    int guard = 0;
    int low_after = 0;
    bit done = 1'b0;
    int bad_order = 0;
    int bad_rdy = 0;
    logic [4:0] wa[$];
    logic [7:0] wd[$];
    logic       wr[$];
    logic [7:0] mem_model[32];
    int         cnt[32];
    logic [7:0] exp_byte;
    foreach (cnt[a]) begin
      cnt[a] = 0;
      mem_model[a] = 8'hxx;
    end
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("ld_in_ready",   32'(in_ready),   32'd1);
    check("ld_halted_clr", 32'(halted),     32'd0);
    check("ld_timeout_clr",32'(timeout),    32'd0);
    check("ld_pc_clr",     32'(halt_pc),    32'd0);
    check("ld_cycles_clr", 32'(run_cycles), 32'd0);
    while (!done && guard < 400) begin
      if (mem_write) begin
        wa.push_back(mem_addr);
        wd.push_back(mem_data);
        wr.push_back(in_ready);
      end else if (wa.size() == 32 && !cpu_rst_) begin
        low_after++;
      end
      if (cpu_rst_) begin
        done = 1'b1;
      end else begin
        if (sent < n && int'($urandom_range(99)) >= gap_pct) begin
          in_valid = 1'b1;
          in_data  = img[sent];
          in_last  = use_last && (sent == n - 1);
          if (in_ready) sent++;
        end else begin
          in_valid = (sent >= n);
          in_data  = 8'($urandom) | 8'h01;
          in_last  = 1'($urandom);
        end
        @(negedge clock);
        guard++;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("ld_completed", 32'(done), 32'd1);
    check("ld_wr_count", 32'(wa.size()), 32'd32);
    for (int i = 0; i < wa.size(); i++) begin
      if (wa[i] !== 5'(i)) bad_order++;
      if (i >= n && wr[i] !== 1'b0) bad_rdy++;
      cnt[wa[i]]++;
      mem_model[wa[i]] = wd[i];
    end
    check("ld_order", 32'(bad_order), 32'd0);
    check("ld_fill_ready", 32'(bad_rdy), 32'd0);
    for (int a = 0; a < 32; a++) begin
      exp_byte = (a < n) ? img[a] : 8'h00;
      check($sformatf("ld_once_a%0d", a), 32'(cnt[a]), 32'd1);
      check($sformatf("ld_data_a%0d", a), 32'(mem_model[a]), 32'(exp_byte));
    end
    check("ld_rst_low", 32'(low_after), 32'(RST_CYC));
    check("ld_run_start", 32'(run_cycles), 32'd0);
  endtask

  // Run the CPU; halt_at is the run cycle (1-based) carrying halt, 0 for never
  task automatic do_run(input int halt_at, input logic [4:0] pc);
    int k = 1;
    bit stopped = 1'b0;
    int stray = 0;
    bit exp_halt;
    int exp_stop;
    logic [4:0] exp_pc;
    exp_halt = (halt_at >= 1) && (halt_at <= int'(MAXC));
    exp_stop = exp_halt ? halt_at : int'(MAXC);
    exp_pc   = exp_halt ? pc : 5'h00;
    while (!stopped && k <= 100) begin
      halt    = (k == halt_at);
      pc_addr = (k == halt_at) ? pc : 5'($urandom);
      start   = (k == 2);
      @(negedge clock);
      halt  = 1'b0;
      start = 1'b0;
      if (mem_write || in_ready || !cpu_rst_) stray++;
      if (halted) stopped = 1'b1;
      else k++;
    end
    check("run_stopped",   32'(stopped),    32'd1);
    check("run_len",       32'(k),          32'(exp_stop));
    check("run_timeout",   32'(timeout),    32'(!exp_halt));
    check("run_halt_pc",   32'(halt_pc),    32'(exp_pc));
    check("run_cycles",    32'(run_cycles), 32'(exp_stop));
    check("run_no_stray",  32'(stray),      32'd0);
    repeat (4) begin
      halt    = 1'($urandom);
      pc_addr = 5'($urandom);
      @(negedge clock);
    end
    halt = 1'b0;
    check("hold_halted",  32'(halted),     32'd1);
    check("hold_timeout", 32'(timeout),    32'(!exp_halt));
    check("hold_pc",      32'(halt_pc),    32'(exp_pc));
    check("hold_cycles",  32'(run_cycles), 32'(exp_stop));
    check("hold_cpu_rst", 32'(cpu_rst_),   32'd1);
    check("hold_no_write",32'(mem_write),  32'd0);
  endtask

  task automatic make_img(input int n);
    img.delete();
    for (int i = 0; i < n; i++) img.push_back(8'($urandom));
  endtask

  initial begin
    @(negedge clock);
    check_reset("por");
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_cpu_rst",  32'(cpu_rst_), 32'd0);

    // Full 32-byte image back-to-back, CPU halts at pc 5'h17
    make_img(32);
    do_load(1'b0, 0);
    do_run(7, 5'h17);

    // Short image terminated by in_last, random gaps, CPU never halts
    make_img(3);
    do_load(1'b1, 30);
    do_run(0, 5'h00);

    // Reset in the middle of a load
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_last  = 1'b0;
      @(negedge clock);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset("rst_midload");
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    check("post_rst_ready", 32'(in_ready), 32'd0);

    // Reload from address 0, then reset mid-run
    make_img(32);
    do_load(1'b1, 25);
    repeat (5) @(negedge clock);
    check("run_count5", 32'(run_cycles), 32'd5);
    rst = 1'b1;
    #1;
    check_reset("rst_midrun");
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);

    // Halt on the very cycle the limit is reached: halt wins
    make_img(int'($urandom_range(31, 1)));
    do_load(1'b1, 40);
    do_run(int'(MAXC), 5'($urandom));

    // Random loads and runs
    for (int t = 0; t < 3; t++) begin
      make_img(int'($urandom_range(32, 1)));
      do_load(1'b1, int'($urandom_range(60)));
      do_run(int'($urandom_range(23)), 5'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
